// File: rtl/equal_frame_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : equal_frame_checker_if                                    |
// | Brief    : Request/bit/result bundle between a comparator stream     |
// |            source and the equal_frame_checker.                       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface equal_frame_checker_if #(
   parameter int CNT_W = 8
);
   // request and per-bit stream
   logic             start;
   logic [CNT_W-1:0] frame_len;
   logic             bit_valid;
   logic             equal;

   // frame result
   logic             busy;
   logic             done;
   logic             match;
   logic [CNT_W-1:0] mismatch_cnt;
   logic [CNT_W-1:0] first_mis_idx;

   modport master (
      output start,
      output frame_len,
      output bit_valid,
      output equal,
      input  busy,
      input  done,
      input  match,
      input  mismatch_cnt,
      input  first_mis_idx
   );

   modport slave (
      input  start,
      input  frame_len,
      input  bit_valid,
      input  equal,
      output busy,
      output done,
      output match,
      output mismatch_cnt,
      output first_mis_idx
   );
endinterface
`default_nettype wire

// File: rtl/equal_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : equal_frame_checker                                       |
// | Brief    : Counts mismatching bits of a frame fed by a 1-bit         |
// |            comparator and reports match / count / first index.       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module equal_frame_checker #(
   parameter int CNT_W = 8
) (
   input  wire                   clk,
   input  wire                   reset,
   equal_frame_checker_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPARE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_one     = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [CNT_W-1:0] r_frame_len;
   logic [CNT_W-1:0] r_mis_cnt;
   logic [CNT_W-1:0] r_first_idx;
   logic             r_first_flag;
   logic             r_match;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_bit_cnt_nxt;
   logic [CNT_W-1:0] w_frame_len_nxt;
   logic [CNT_W-1:0] w_mis_cnt_nxt;
   logic [CNT_W-1:0] w_first_idx_nxt;
   logic             w_first_flag_nxt;
   logic             w_match_nxt;
   logic             w_last_bit;

   // bit_cnt stays below the captured length while comparing, so this never underflows
   assign w_last_bit = (r_bit_cnt == (r_frame_len - c_one));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_bit_cnt    <= '0;
         r_frame_len  <= '0;
         r_mis_cnt    <= '0;
         r_first_idx  <= '0;
         r_first_flag <= 1'b0;
         r_match      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_frame_len  <= w_frame_len_nxt;
         r_mis_cnt    <= w_mis_cnt_nxt;
         r_first_idx  <= w_first_idx_nxt;
         r_first_flag <= w_first_flag_nxt;
         r_match      <= w_match_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_frame_len_nxt  = r_frame_len;
      w_mis_cnt_nxt    = r_mis_cnt;
      w_first_idx_nxt  = r_first_idx;
      w_first_flag_nxt = r_first_flag;
      w_match_nxt      = r_match;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_frame_len_nxt  = bus.frame_len;
               w_bit_cnt_nxt    = '0;
               w_mis_cnt_nxt    = '0;
               w_first_idx_nxt  = '0;
               w_first_flag_nxt = 1'b0;
               if (bus.frame_len == '0) begin
                  // an empty frame trivially matches
                  w_state_nxt = S_DONE;
                  w_match_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_COMPARE;
                  w_match_nxt = 1'b0;
               end
            end
         end

         S_COMPARE: begin
            if (bus.bit_valid) begin
               w_bit_cnt_nxt = r_bit_cnt + c_one;
               if (!bus.equal) begin
                  if (r_mis_cnt != c_cnt_max) begin
                     w_mis_cnt_nxt = r_mis_cnt + c_one;
                  end
                  if (!r_first_flag) begin
                     w_first_idx_nxt  = r_bit_cnt;
                     w_first_flag_nxt = 1'b1;
                  end
               end
               // match is resolved on the same edge so it already includes the last bit
               if (w_last_bit) begin
                  w_state_nxt = S_DONE;
                  w_match_nxt = (w_mis_cnt_nxt == '0);
               end
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.busy          = (r_state != S_IDLE);
   assign bus.done          = (r_state == S_DONE);
   assign bus.match         = r_match;
   assign bus.mismatch_cnt  = r_mis_cnt;
   assign bus.first_mis_idx = r_first_idx;

endmodule
`default_nettype wire

// File: tb/tb_equal_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_equal_frame_checker                                    |
// | Brief    : Directed scoreboard bench; an 8-bit and a 2-bit checker   |
// |            share one stimulus stream, one is observed at a time.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_equal_frame_checker;

   typedef struct {
      logic [7:0] mis;
      logic [7:0] first;
      logic       match;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] frame_len;
   logic       bit_valid;
   logic       equal;
   logic       sel;   // 0: observe CNT_W=8 instance, 1: observe CNT_W=2 instance

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   equal_frame_checker_if #(.CNT_W(8)) if8 ();
   equal_frame_checker_if #(.CNT_W(2)) if2 ();

   equal_frame_checker #(.CNT_W(8)) u_dut8 (.clk(clk), .reset(reset), .bus(if8));
   equal_frame_checker #(.CNT_W(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

   assign if8.start     = start;
   assign if8.frame_len = frame_len;
   assign if8.bit_valid = bit_valid;
   assign if8.equal     = equal;
   assign if2.start     = start;
   assign if2.frame_len = frame_len[1:0];
   assign if2.bit_valid = bit_valid;
   assign if2.equal     = equal;

   logic       o_busy, o_done, o_match;
   logic [7:0] o_mis, o_first;
   assign o_busy  = sel ? if2.busy  : if8.busy;
   assign o_done  = sel ? if2.done  : if8.done;
   assign o_match = sel ? if2.match : if8.match;
   assign o_mis   = sel ? {6'd0, if2.mismatch_cnt}  : if8.mismatch_cnt;
   assign o_first = sel ? {6'd0, if2.first_mis_idx} : if8.first_mis_idx;

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input int len, input logic [15:0] eq);
      exp_t e;
      int   sat;
      bit   seen;
      sat     = sel ? 3 : 255;
      e.mis   = 8'd0;
      e.first = 8'd0;
      seen    = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (!eq[i]) begin
            if (int'(e.mis) < sat) e.mis = e.mis + 8'd1;
            if (!seen) begin
               e.first = 8'(i);
               seen    = 1'b1;
            end
         end
      end
      e.match = (e.mis == 8'd0);
      return e;
   endfunction

   task automatic compare_result(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 8'd1, 8'd0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_mis"},   o_mis,   e.mis);
         chk({tag, "_first"}, o_first, e.first);
         chk({tag, "_match"}, {7'd0, o_match}, {7'd0, e.match});
      end
   endtask

   // noise=1 pulses start (with a different frame_len) through COMPARE and DONE
   task automatic run_frame(input string tag, input int len, input logic [15:0] eq,
                            input logic [15:0] gap, input bit noise);
      exp_t e;
      e = model(len, eq);
      sb.push_back(e);
      start     = 1'b1;
      frame_len = 8'(len);
      step();
      start = noise;
      if (noise) frame_len = 8'd0;
      if (len == 0) begin
         chk({tag, "_z_done"}, {7'd0, o_done}, 8'd1);
         chk({tag, "_z_busy"}, {7'd0, o_busy}, 8'd1);
         compare_result(tag);
         start = 1'b0;
         step();
         chk({tag, "_z_busy_off"}, {7'd0, o_busy}, 8'd0);
         return;
      end
      chk({tag, "_busy"}, {7'd0, o_busy}, 8'd1);
      for (int i = 0; i < len; i++) begin
         if (gap[i]) begin
            bit_valid = 1'b0;
            equal     = 1'b0;
            step();
            chk({tag, "_gap_done"}, {7'd0, o_done}, 8'd0);
         end
         bit_valid = 1'b1;
         equal     = eq[i];
         step();
         if (i < len - 1) chk({tag, "_early_done"}, {7'd0, o_done}, 8'd0);
      end
      bit_valid = 1'b0;
      equal     = 1'b1;
      chk({tag, "_latency_done"}, {7'd0, o_done}, 8'd1);
      compare_result(tag);
      step();
      chk({tag, "_idle_busy"}, {7'd0, o_busy}, 8'd0);
      chk({tag, "_idle_done"}, {7'd0, o_done}, 8'd0);
      chk({tag, "_match_hold"}, {7'd0, o_match}, {7'd0, e.match});
      if (noise) begin
         // start still high in this IDLE cycle with frame_len=0: accepted
         sb.push_back(model(0, 16'hFFFF));
         step();
         chk({tag, "_restart_busy"}, {7'd0, o_busy}, 8'd1);
         chk({tag, "_restart_done"}, {7'd0, o_done}, 8'd1);
         compare_result({tag, "_restart"});
         start = 1'b0;
         step();
         chk({tag, "_restart_idle"}, {7'd0, o_busy}, 8'd0);
      end
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_busy"},  {7'd0, o_busy},  8'd0);
      chk({tag, "_done"},  {7'd0, o_done},  8'd0);
      chk({tag, "_match"}, {7'd0, o_match}, 8'd0);
      chk({tag, "_mis"},   o_mis,   8'd0);
      chk({tag, "_first"}, o_first, 8'd0);
   endtask

   initial begin
      sel       = 1'b0;
      reset     = 1'b1;
      start     = 1'b0;
      frame_len = 8'd0;
      bit_valid = 1'b0;
      equal     = 1'b1;
      step();
      step();
      check_cleared("reset8");
      sel = 1'b1;
      check_cleared("reset2");
      sel = 1'b0;

      // reset wins over a simultaneous start
      start     = 1'b1;
      frame_len = 8'd4;
      step();
      chk("rst_prio_busy", {7'd0, o_busy}, 8'd0);
      start = 1'b0;
      reset = 1'b0;

      run_frame("all_eq", 4, 16'h000F, 16'h0000, 1'b0);
      run_frame("alt_gap", 4, 16'h0005, 16'h0004, 1'b0);
      run_frame("zero_len", 0, 16'h0000, 16'h0000, 1'b0);
      run_frame("long", 11, 16'h06F7, 16'h0091, 1'b0);
      run_frame("noise", 3, 16'h0006, 16'h0002, 1'b0);
      run_frame("start_ignored", 3, 16'h0003, 16'h0000, 1'b1);

      // abort mid-frame after 2 of 4 bits
      sb.push_back(model(4, 16'h0001));
      start     = 1'b1;
      frame_len = 8'd4;
      step();
      start = 1'b0;
      bit_valid = 1'b1;
      equal = 1'b1;
      step();
      equal = 1'b0;
      step();
      chk("abort_pre_mis",   o_mis,   8'd1);
      chk("abort_pre_first", o_first, 8'd1);
      bit_valid = 1'b1;
      reset     = 1'b1;
      step();
      void'(sb.pop_front());
      check_cleared("abort");
      reset     = 1'b0;
      bit_valid = 1'b0;
      run_frame("after_abort", 2, 16'h0002, 16'h0000, 1'b0);

      // saturation boundary on the 2-bit instance
      sel = 1'b1;
      run_frame("sat", 3, 16'h0000, 16'h0000, 1'b0);
      reset = 1'b1;
      step();
      check_cleared("sat_reset");
      reset = 1'b0;
      run_frame("sat_rerun", 3, 16'h0000, 16'h0001, 1'b0);
      run_frame("small_match", 2, 16'h0003, 16'h0000, 1'b0);

      chk("sb_drained", 8'(sb.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/equal_frame_checker.md
EQUAL_FRAME_CHECKER -- requirements
Module: equal_frame_checker

Interface
REQ-001 Parameter CNT_W, default 8: width of frame_len, bit index and mismatch counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a comparison frame; sampled only in IDLE.
REQ-005 frame_len  input  CNT_W  number of compared bits in the frame; captured when start is accepted.
REQ-006 bit_valid  input  1  qualifies equal for the current cycle.
REQ-007 equal  input  1  per-bit result from the upstream 1-bit comparator: 1 means a==b.
REQ-008 busy  output  1  high while in COMPARE or DONE.
REQ-009 done  output  1  one-cycle pulse at frame end.
REQ-010 match  output  1  frame had zero mismatches; valid from done until the next accepted start.
REQ-011 mismatch_cnt  output  CNT_W  number of bits with equal=0 in the frame; saturating.
REQ-012 first_mis_idx  output  CNT_W  0-based index of the first mismatching bit; 0 if none.

Function
REQ-013 FSM states: IDLE, COMPARE, DONE; encoding is free; one registered state variable.
REQ-014 IDLE with start=1 and frame_len!=0 -> COMPARE; capture frame_len; clear bit_cnt, mismatch_cnt, first_mis_idx, match and the internal first-mismatch flag.
REQ-015 IDLE with start=1 and frame_len=0 -> DONE directly; counters cleared; match=1 at done.
REQ-016 IDLE with start=0 -> stay in IDLE; all result outputs hold.
REQ-017 COMPARE, bit_valid=1: accept one bit.
  - bit_cnt increments.
  - If equal=0, mismatch_cnt increments.
  - If equal=0 and no earlier mismatch, first_mis_idx = current bit_cnt and the flag is set.
REQ-018 COMPARE, bit_valid=0: no state change; bit_cnt holds.
REQ-019 The bit that brings bit_cnt to the captured frame_len is the last bit; next state is DONE.
REQ-020 DONE lasts exactly one cycle: done=1; match=(mismatch_cnt==0), counting the last bit; then -> IDLE.
REQ-021 Latency: done is high in the cycle immediately after the clock edge that accepts the last bit.
REQ-022 mismatch_cnt saturates at 2^CNT_W-1 and does not wrap.
REQ-023 bit_cnt never exceeds frame_len; bit_valid in IDLE or DONE is ignored.
REQ-024 start in COMPARE or DONE is ignored; it is not queued. start in the IDLE cycle after DONE is accepted normally.
REQ-025 frame_len changes after capture have no effect on the running frame.
REQ-026 busy is high in COMPARE and DONE and low in IDLE; all outputs are registered or decoded from registered state.

Reset
REQ-027 reset=1 at a clock edge forces IDLE from any state, including mid-frame.
  - busy=0, done=0, match=0, mismatch_cnt=0, first_mis_idx=0.
  - bit_cnt and captured frame_len are cleared.
REQ-028 reset has priority over start and bit_valid in the same cycle.
REQ-029 The first start is accepted on the first edge after reset deasserts.

Verification
REQ-030 frame_len=4; equal=1,1,1,1, bit_valid continuous -> done 1 cycle after the 4th bit; match=1, mismatch_cnt=0, first_mis_idx=0.
REQ-031 frame_len=4; equal=1,0,1,0 with a bit_valid=0 gap after bit 1 -> match=0, mismatch_cnt=2, first_mis_idx=1; the gap adds one cycle to done latency.
REQ-032 frame_len=0 with start -> DONE on the next edge; done=1, match=1, busy high for exactly 1 cycle.
REQ-033 CNT_W=2; frame_len=3; equal=0,0,0 -> mismatch_cnt=3 (saturation boundary); then reset and rerun, checking it does not wrap.
REQ-034 reset=1 after 2 of 4 bits -> next cycle IDLE with all outputs 0; a new start with frame_len=2 completes normally.
REQ-035 start pulsed during COMPARE and during DONE -> no effect; busy falls after DONE, and start in the following IDLE cycle is accepted.
